// File: rtl/strobe_decoder_pkg.sv
// -----------------------------------------------------------------------------
// strobe_decoder_pkg
// Shared types and constants for the strobe decoder.
//   state_t    : decoder FSM state (IDLE / HOLD / PULSE)
//   MODE_HOLD  : mode value selecting a held one-hot output
//   MODE_PULSE : mode value selecting a timed strobe
// -----------------------------------------------------------------------------
package strobe_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        PULSE = 2'd2
    } state_t;

    localparam logic MODE_HOLD  = 1'b0;
    localparam logic MODE_PULSE = 1'b1;

endpackage : strobe_decoder_pkg

// File: rtl/strobe_decoder_timer.sv
// -----------------------------------------------------------------------------
// strobe_timer
// Saturating down-counter that times a PULSE strobe.
// Parameters:
//   PULSE_LEN : strobe length in cycles (>= 1); load value is PULSE_LEN-1
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset (counter -> 0)
//   clr   : synchronous clear, highest priority after reset
//   load  : load PULSE_LEN-1
//   count : decrement by one (stops at zero, never wraps)
//   done  : counter is zero
// -----------------------------------------------------------------------------
module strobe_timer #(
    parameter int PULSE_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic load,
    input  logic count,
    output logic done
);

    localparam int CNT_W = $clog2(PULSE_LEN + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PULSE_LEN - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= LOAD_VAL;
        end else if (count && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    assign done = (cnt_reg == '0);

endmodule : strobe_timer

// File: rtl/strobe_decoder.sv
// -----------------------------------------------------------------------------
// strobe_decoder
// Registered one-hot decoder with HOLD and timed PULSE output modes.
// Optional macro: DECODER_RANGE_CHECK_EN -- adds the err port and rejects
// out-of-range selects (out stays 0, err pulses for one cycle).
// Parameters:
//   IN_W      : select index width
//   NUM_OUT   : number of one-hot outputs (2 .. 2**IN_W)
//   PULSE_LEN : strobe length in PULSE mode (>= 1)
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : block enable, low forces everything idle
//   mode       : 0 = HOLD, 1 = PULSE (sampled on accept)
//   in_valid   : select request valid
//   in_ready   : a select can be accepted this cycle
//   in_sel     : index to decode
//   out        : registered one-hot decode (or zero)
//   busy       : PULSE strobe in progress
//   err        : out-of-range flag (only with DECODER_RANGE_CHECK_EN)
// -----------------------------------------------------------------------------
module strobe_decoder
    import strobe_decoder_pkg::*;
#(
    parameter int IN_W      = 4,
    parameter int NUM_OUT   = 16,
    parameter int PULSE_LEN = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_sel,
    output logic [NUM_OUT-1:0] out,
    output logic               busy
`ifdef DECODER_RANGE_CHECK_EN
    ,
    output logic               err
`endif
);

    state_t             state_reg;
    state_t             state_next;
    logic [NUM_OUT-1:0] out_reg;
    logic [NUM_OUT-1:0] out_next;
    logic [NUM_OUT-1:0] onehot;
    logic               accept;
    logic               timer_done;
    logic               timer_load;
    logic               timer_count;
    logic               timer_clr;
    logic               sel_ok;

`ifdef DECODER_RANGE_CHECK_EN
    localparam int IN_W1 = IN_W + 1;
    localparam logic [IN_W:0] NUM_OUT_W = IN_W1'(NUM_OUT);

    logic err_reg;
    logic err_next;

    // One extra bit so NUM_OUT == 2**IN_W is representable.
    assign sel_ok = ({1'b0, in_sel} < NUM_OUT_W);
`else
    // Out-of-range selects decode to zero through truncation of the one-hot.
    assign sel_ok = 1'b1;
`endif

    // Only NUM_OUT bits are decoded, so indices >= NUM_OUT yield all zero.
    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_dec
            assign onehot[gi] = (in_sel == IN_W'(gi));
        end
    endgenerate

    // rst_n gates ready so nothing is advertised while reset is held.
    assign in_ready = rst_n & enable & (state_reg != PULSE);
    assign accept   = in_valid & in_ready;

    strobe_timer #(
        .PULSE_LEN (PULSE_LEN)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .load  (timer_load),
        .count (timer_count),
        .done  (timer_done)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (!enable) begin
            state_next = IDLE;
        end else if (accept) begin
            if (!sel_ok) begin
                state_next = IDLE;
            end else if (mode == MODE_PULSE) begin
                state_next = PULSE;
            end else begin
                state_next = HOLD;
            end
        end else if ((state_reg == PULSE) && timer_done) begin
            state_next = IDLE;
        end
    end

    // Output / datapath control logic
    always_comb begin
        out_next    = out_reg;
        timer_clr   = !enable;
        timer_load  = accept && sel_ok && (mode == MODE_PULSE);
        timer_count = (state_reg == PULSE);
`ifdef DECODER_RANGE_CHECK_EN
        err_next    = 1'b0;
`endif
        if (!enable) begin
            out_next = '0;
        end else if (accept) begin
            out_next = sel_ok ? onehot : '0;
`ifdef DECODER_RANGE_CHECK_EN
            err_next = !sel_ok;
`endif
        end else if ((state_reg == PULSE) && timer_done) begin
            out_next = '0;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg <= '0;
        end else begin
            out_reg <= out_next;
        end
    end

`ifdef DECODER_RANGE_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign err = err_reg;
`endif

    assign out  = out_reg;
    assign busy = (state_reg == PULSE);

endmodule : strobe_decoder

// File: tb/tb_strobe_decoder.sv
// -----------------------------------------------------------------------------
// tb_strobe_decoder
// Three decoder instances share the request inputs and have private enables:
//   dut_a : defaults (16 outputs, PULSE_LEN = 4)
//   dut_b : PULSE_LEN = 1
//   dut_c : NUM_OUT = 10
// -----------------------------------------------------------------------------
module tb_strobe_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, en_b, en_c;
    logic        mode, in_valid;
    logic [3:0]  in_sel;
    logic        rdy_a, rdy_b, rdy_c;
    logic [15:0] out_a, out_b;
    logic [9:0]  out_c;
    logic        busy_a, busy_b, busy_c;
`ifdef DECODER_RANGE_CHECK_EN
    logic        err_a, err_b, err_c;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    strobe_decoder #(.IN_W(4), .NUM_OUT(16), .PULSE_LEN(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .mode(mode),
        .in_valid(in_valid), .in_ready(rdy_a), .in_sel(in_sel),
        .out(out_a), .busy(busy_a)
`ifdef DECODER_RANGE_CHECK_EN
        , .err(err_a)
`endif
    );

    strobe_decoder #(.IN_W(4), .NUM_OUT(16), .PULSE_LEN(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .mode(mode),
        .in_valid(in_valid), .in_ready(rdy_b), .in_sel(in_sel),
        .out(out_b), .busy(busy_b)
`ifdef DECODER_RANGE_CHECK_EN
        , .err(err_b)
`endif
    );

    strobe_decoder #(.IN_W(4), .NUM_OUT(10), .PULSE_LEN(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .enable(en_c), .mode(mode),
        .in_valid(in_valid), .in_ready(rdy_c), .in_sel(in_sel),
        .out(out_c), .busy(busy_c)
`ifdef DECODER_RANGE_CHECK_EN
        , .err(err_c)
`endif
    );

    typedef struct packed {
        logic        en;
        logic        valid;
        logic        mode;
        logic [3:0]  sel;
        logic [7:0]  rep;
        logic [15:0] exp_out;
        logic        exp_busy;
        logic        exp_ready;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // en, valid, mode, sel, rep, out, busy, ready
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'h5, 8'd1, 16'h0020, 1'b0, 1'b1}; // HOLD 5
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'h0, 8'd9, 16'h0020, 1'b0, 1'b1}; // held
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 4'hF, 8'd1, 16'h8000, 1'b0, 1'b1}; // no gap
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 4'h3, 8'd1, 16'h0008, 1'b1, 1'b0}; // PULSE 3
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 4'h7, 8'd3, 16'h0008, 1'b1, 1'b0}; // req waits
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 4'h7, 8'd1, 16'h0000, 1'b0, 1'b1}; // pulse over
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 4'h7, 8'd1, 16'h0080, 1'b0, 1'b1}; // waiting req
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 4'hA, 8'd1, 16'h0400, 1'b1, 1'b0}; // PULSE A
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 4'hA, 8'd1, 16'h0000, 1'b0, 1'b0}; // enable drop
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'hA, 8'd2, 16'h0000, 1'b0, 1'b0}; // not accepted
        vecs[10] = '{1'b1, 1'b1, 1'b0, 4'hA, 8'd1, 16'h0400, 1'b0, 1'b1}; // accepted
        vecs[11] = '{1'b1, 1'b0, 1'b0, 4'h0, 8'd1, 16'h0400, 1'b0, 1'b1}; // hold

        // Reset state
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        mode = 1'b0; in_valid = 1'b0; in_sel = 4'h0;
        #1;
        chk("reset_out_a", 32'(out_a), 32'h0);
        chk("reset_busy_a", 32'(busy_a), 32'h0);
        en_a = 1'b1;
        #1;
        chk("reset_ready_a", 32'(rdy_a), 32'h0);
        step();
        chk("reset_hold_out_a", 32'(out_a), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("post_reset_ready_a", 32'(rdy_a), 32'h1);

        // Table-driven main sequence on dut_a
        for (int v = 0; v < 12; v++) begin
            en_a = vecs[v].en; in_valid = vecs[v].valid;
            mode = vecs[v].mode; in_sel = vecs[v].sel;
            for (int r = 0; r < int'(vecs[v].rep); r++) begin
                step();
                chk($sformatf("vec%0d_c%0d_out", v, r), 32'(out_a), 32'(vecs[v].exp_out));
                chk($sformatf("vec%0d_c%0d_busy", v, r), 32'(busy_a), 32'(vecs[v].exp_busy));
                chk($sformatf("vec%0d_c%0d_ready", v, r), 32'(rdy_a), 32'(vecs[v].exp_ready));
            end
        end

        // Asynchronous reset between edges while in HOLD
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out", 32'(out_a), 32'h0);
        chk("async_rst_ready", 32'(rdy_a), 32'h0);
        #1 rst_n = 1'b1;
        en_a = 1'b1; in_valid = 1'b1; mode = 1'b0; in_sel = 4'h6;
        step();
        chk("first_accept_after_rst", 32'(out_a), 32'h0040);

        // HOLD sweep on dut_a
        for (int i = 0; i < 16; i++) begin
            in_sel = 4'(i);
            step();
            chk($sformatf("hold_sweep_%0d", i), 32'(out_a), 32'(16'(1) << i));
        end
        en_a = 1'b0; in_valid = 1'b0;
        step();
        chk("disable_a_out", 32'(out_a), 32'h0);

        // Single-cycle strobe sweep on dut_b (PULSE_LEN = 1)
        en_b = 1'b1; mode = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_sel = 4'(i);
            step();
            chk($sformatf("p1_sweep_%0d_out", i), 32'(out_b), 32'(16'(1) << i));
            chk($sformatf("p1_sweep_%0d_busy", i), 32'(busy_b), 32'h1);
            in_sel = 4'(i + 1);
            step();
            chk($sformatf("p1_sweep_%0d_gap", i), 32'(out_b), 32'h0);
            chk($sformatf("p1_sweep_%0d_gapbusy", i), 32'(busy_b), 32'h0);
            chk($sformatf("p1_sweep_%0d_ready", i), 32'(rdy_b), 32'h1);
        end
        en_b = 1'b0; in_valid = 1'b0;
        step();

        // Range behaviour on dut_c (NUM_OUT = 10)
        en_c = 1'b1; mode = 1'b0; in_valid = 1'b1; in_sel = 4'h9;
        step();
        chk("c_in_range", 32'(out_c), 32'h200);
        in_sel = 4'hC;
        step();
        chk("c_out_of_range_out", 32'(out_c), 32'h0);
`ifdef DECODER_RANGE_CHECK_EN
        chk("c_err_set", 32'(err_c), 32'h1);
        chk("c_err_state_idle", 32'(busy_c), 32'h0);
`endif
        in_valid = 1'b0;
        step();
        chk("c_after_out", 32'(out_c), 32'h0);
`ifdef DECODER_RANGE_CHECK_EN
        chk("c_err_clear", 32'(err_c), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_strobe_decoder

// File: doc/strobe_decoder.md
STROBE_DECODER -- requirements
Module: strobe_decoder

Interface
REQ-001 Parameter IN_W, default 4, width of the select index.
REQ-002 Parameter NUM_OUT, default 16, number of one-hot outputs; legal range 2..2**IN_W.
REQ-003 Parameter PULSE_LEN, default 4, strobe length in cycles for pulse mode; legal range >= 1.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 enable  input  1  block enable; low forces outputs off.
REQ-007 mode  input  1  per-transaction mode, sampled with the select: 0 = HOLD, 1 = PULSE.
REQ-008 in_valid  input  1  select request valid.
REQ-009 in_ready  output  1  block can accept a select this cycle.
REQ-010 in_sel  input  IN_W  index to decode.
REQ-011 out  output  NUM_OUT  registered one-hot decode, or all zero.
REQ-012 busy  output  1  high while a PULSE strobe is in progress.
REQ-013 err  output  1  out-of-range flag; exists only when DECODER_RANGE_CHECK_EN is defined.

Function
REQ-014 The block SHALL accept a transaction on a rising edge where in_valid, in_ready and enable are all 1.
REQ-015 The block SHALL present out = 1 << in_sel, with in_sel taken from the accepting edge, starting the cycle after accept (latency 1 cycle).
REQ-016 The FSM SHALL have three states: IDLE (out = 0), HOLD and PULSE.
REQ-017 in_ready SHALL be enable AND (state != PULSE), and 0 while rst_n is low.
REQ-018 Accept with mode = 0 SHALL enter HOLD; out stays constant until the next accept or until enable goes low.
REQ-019 Accept in HOLD SHALL replace out on the next cycle with no all-zero gap; a mode = 1 accept moves to PULSE.
REQ-020 Accept with mode = 1 SHALL enter PULSE and load the counter with PULSE_LEN-1.
REQ-021 In PULSE, out SHALL stay asserted for exactly PULSE_LEN cycles, and busy = 1 for those same cycles.
REQ-022 PULSE SHALL return to IDLE when the counter reaches 0, and out SHALL be 0 the following cycle.
REQ-023 In PULSE, in_valid SHALL be ignored; requests are neither queued nor lost, they wait on in_ready.
REQ-024 PULSE_LEN = 1 SHALL produce a single-cycle strobe; back-to-back PULSE transactions are therefore separated by at least one IDLE cycle.
REQ-025 enable = 0 on any rising edge SHALL force IDLE, out = 0, busy = 0 and counter = 0 on that edge; this overrides every other event, including an in-flight pulse.
REQ-026 The counter SHALL be ceil(log2(PULSE_LEN+1)) bits wide, count down only, and never wrap.

Reset
REQ-027 Asserting rst_n low SHALL immediately force state IDLE, out = 0, busy = 0, err = 0, counter = 0 and in_ready = 0, independent of clk.
REQ-028 After rst_n deasserts, the first accept SHALL be possible on the first rising edge with enable = 1.

Configuration
REQ-029 Macro DECODER_RANGE_CHECK_EN defined: an accept with in_sel >= NUM_OUT SHALL leave out = 0, pulse err high for one cycle and put the FSM in IDLE.
REQ-030 Macro DECODER_RANGE_CHECK_EN undefined: an out-of-range accept SHALL proceed normally, with the one-hot truncated to NUM_OUT bits (out = 0), and no err port SHALL exist.

Structure
REQ-031 Package strobe_decoder_pkg SHALL hold the state enum (IDLE/HOLD/PULSE) and the mode constants MODE_HOLD = 0 and MODE_PULSE = 1.
REQ-032 The down-counter SHALL be a sub-module strobe_timer (load, count, done), parametrised by PULSE_LEN.

Verification
REQ-033 Reset, then enable = 1; HOLD accept in_sel = 4'h5 -> out = 16'h0020 the next cycle, held 10 cycles; then HOLD accept 4'hF -> out = 16'h8000 with no zero cycle.
REQ-034 PULSE accept in_sel = 4'h3, PULSE_LEN = 4 -> out = 16'h0008 and busy = 1 for exactly 4 cycles, in_ready = 0 throughout, then out = 0 and in_ready = 1.
REQ-035 enable dropped on the 2nd cycle of a pulse on 4'hA -> out = 0 and busy = 0 at that edge; in_valid held high is not accepted until enable = 1.
REQ-036 rst_n pulsed low mid-HOLD between clock edges -> out = 0 and in_ready = 0 immediately, without waiting for an edge.
REQ-037 NUM_OUT = 10 with macro defined, accept in_sel = 4'hC -> out = 0 and err = 1 for one cycle; without the macro -> out = 0 and no err port.
REQ-038 Sweep all 16 indices in HOLD with enable = 1 -> out equals 1 << in_sel for each; repeat with PULSE_LEN = 1 -> each index gives a 1-cycle strobe.
